// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
module muldiv_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] a_reg;      // raw rs operand (multiplicand, or dividend for div-by-zero)
    logic [31:0] b_reg;      // raw multiplier, or divisor magnitude
    logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
    logic [31:0] rem;        // partial remainder (always below the divisor)
    logic        uns_reg;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        mul_commit;
    logic        div_commit;
    logic        cnt_zero;

    logic [63:0] mul_a, mul_b, product;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [31:0] q_fix, r_fix;
    logic        div_zero;

    assign busy     = (state != S_IDLE);
    assign cnt_zero = (cnt == 5'd0);

    // Product is formed from the latched operands; the counter only models latency.
    assign mul_a   = uns_reg ? {32'd0, a_reg} : {{32{a_reg[31]}}, a_reg};
    assign mul_b   = uns_reg ? {32'd0, b_reg} : {{32{b_reg[31]}}, b_reg};
    assign product = mul_a * mul_b;

    // One restoring step: shift in the next dividend bit and try the subtraction.
    // When the 33-bit compare succeeds the difference is below the divisor, so
    // a 32-bit subtract is exact.
    assign rem_shift = {rem, quo[31]};
    assign rem_ge    = (rem_shift >= {1'b0, b_reg});
    assign rem_sub   = rem_shift[31:0] - b_reg;

    // Sign fix-up and divide-by-zero override applied on the FIX cycle.
    assign q_fix    = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix    = neg_r ? (~rem + 32'd1) : rem;
    assign div_zero = (b_reg == 32'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and commit decode; cancel outranks any commit in the same cycle.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        mul_commit = 1'b0;
        div_commit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_nxt = S_IDLE;
                end else if (cnt_zero) begin
                    mul_commit = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_nxt = S_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (!cancel) begin
                    div_commit = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latches, latency counter and divider iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            uns_reg <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            a_reg   <= rs_val;
            uns_reg <= op[0];
            rem     <= 32'd0;
            if (op[1]) begin
                cnt   <= 5'd31;
                b_reg <= (op[0] || !rt_val[31]) ? rt_val : (~rt_val + 32'd1);
                quo   <= (op[0] || !rs_val[31]) ? rs_val : (~rs_val + 32'd1);
                neg_q <= !op[0] && (rs_val[31] ^ rt_val[31]);
                neg_r <= !op[0] && rs_val[31];
            end else begin
                cnt   <= 5'(MUL_LAT - 1);
                b_reg <= rt_val;
                quo   <= 32'd0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
        end else if (state == S_MUL) begin
            if (!cnt_zero) begin
                cnt <= cnt - 5'd1;
            end
        end else if (state == S_DIV) begin
            rem <= rem_ge ? rem_sub : rem_shift[31:0];
            quo <= {quo[30:0], rem_ge};
            cnt <= cnt - 5'd1;
        end
    end

    // HI/LO: commits from the datapath, or MTHI/MTLO writes while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (mul_commit) begin
            hi <= product[63:32];
            lo <= product[31:0];
        end else if (div_commit) begin
            hi <= div_zero ? a_reg : r_fix;
            lo <= div_zero ? 32'hFFFF_FFFF : q_fix;
        end else if (state == S_IDLE) begin
            if (hi_we) begin
                hi <= wdata;
            end
            if (lo_we) begin
                lo <= wdata;
            end
        end
    end

    // Completion pulse in the cycle after the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= mul_commit || div_commit;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS pipeline. It sequences a 32x32 multiplier and a radix-2 iterative divider, and it owns the architectural HI/LO registers. It raises `busy` so the decode stage stalls subsequent MULT/DIV/MFHI/MFLO/MTHI/MTLO until results are committed. It sits beside the EX stage and is fed operands from the forwarding muxes.

## Interface
- `MUL_LAT`, 3: cycles from accepted multiply start to HI/LO commit; legal range 1..8.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `op`  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `cancel`  in  1  abort in-flight operation (exception flush).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO commit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset (async, `rst_n`=0): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counters and operand latches cleared. Reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start`: latch operands, `op`; go to MUL (op 0x) or DIV (op 1x). `start` while `busy`=1 is ignored; no queuing.
- MUL: signed 64-bit product for MULT (operands sign-extended), unsigned for MULTU. Down-counter loaded with MUL_LAT-1. At count 0: `{hi,lo}` <= product, go to IDLE.
- DIV: latch magnitudes (DIV: two's-complement absolute value; DIVU: raw), record sign of dividend and sign(dividend)^sign(divisor). Perform 32 restoring iterations, one quotient bit per cycle, MSB first, on a 33-bit partial remainder. Then go to FIX.
- FIX (1 cycle): quotient negated if the sign XOR is set; remainder negated if the dividend is negative; `lo` <= quotient, `hi` <= remainder; go to IDLE.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields `lo`=0x80000000, `hi`=0. This falls out of the magnitude path and needs no special case.
- Divide by zero (divisor==0, DIV or DIVU): full latency still taken; FIX forces `lo`=0xFFFFFFFF, `hi`=rs_val as latched.
- `cancel`: in MUL/DIV/FIX, return to IDLE at the next edge. HI/LO stay unchanged and no `done` is issued. `cancel` has priority over commit in the same cycle. In IDLE it has no effect and does not block a simultaneous `start`.
- MTHI/MTLO: `hi_we`/`lo_we` write `wdata` only when `busy`=0; ignored while busy. A write in the same cycle as an accepted `start` takes effect; the operation's commit later overwrites it.
- `hi`/`lo` change only at reset, commit, or an idle MT write.

## Timing
- `start` accepted at edge E0; `busy`=1 from E0 until the commit edge; `busy`=0 after commit.
- Multiply: commit at E0+MUL_LAT; `busy` high MUL_LAT cycles.
- Divide: 32 iteration edges plus 1 FIX edge; commit at E0+33; `busy` high 33 cycles.
- `done`=1 for exactly the cycle following the commit edge. The new `hi`/`lo` are visible in that same cycle.
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0, i.e. the `done` cycle.
- `busy` is registered; it has no combinational path from `start`. The decode stall logic ORs in `start` itself.

## Test plan
- MULT, rs=0xFFFFFFFD (-3), rt=5, MUL_LAT=3 -> `busy` high 3 cycles; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `done` pulses once.
- MULTU, rs=rt=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then MULT with the same operands -> `hi`=0, `lo`=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 33 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU same operands -> `lo`=0x7FFFFFFC, `hi`=1.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU rs=0x1234, rt=0 -> `lo`=0xFFFFFFFF, `hi`=0x1234.
- Preload `hi`=0xAAAA via MTHI; start DIV; assert `cancel` on cycle 10 -> `busy`=0 next cycle, no `done`, `hi`=0xAAAA. Pulse `start` and `hi_we` during a busy window -> both ignored.
- Assert `rst_n`=0 asynchronously mid-DIV -> `busy`, `done`, `hi`, `lo` all 0 immediately. After release, a MULT 2*3 completes with `lo`=6, `hi`=0.
